speed_clock_gen: RTL and testbench
==================================

# speed_clock_gen

Clock-generation and speed-control stage for the speed-select path. From the single board clock it derives the 10 Hz and 1 Hz square waves and owns the `speed` mode bit. Together these drive the three inputs of the downstream clock selector, which passes the 10 Hz wave when `speed`=0 and the 1 Hz wave when `speed`=1. It also provides single-cycle tick strobes so board-clock logic can use clock enables instead of the derived clocks.

## Interface
- `CLK_FREQ`, 100_000_000: board clock frequency in Hz.
- `FAST_HZ`, 10: fast output frequency.
- `SLOW_HZ`, 1: slow output frequency.
- `DEB_CYCLES`, 1_000_000: cycles the button must hold a new level before it is accepted (10 ms at 100 MHz).

Ports:
- `clk` input, 1 bit: board clock. The only clock in the block.
- `rst` input, 1 bit: reset, synchronous, active-high.
- `btn_speed` input, 1 bit: raw push-button. Asynchronous and bouncing.
- `clk_10hz` output, 1 bit: 50 % duty square wave at `FAST_HZ`.
- `clk_1hz` output, 1 bit: 50 % duty square wave at `SLOW_HZ`.
- `tick_10hz` output, 1 bit: one-cycle strobe, high in the cycle `clk_10hz` rises.
- `tick_1hz` output, 1 bit: one-cycle strobe, high in the cycle `clk_1hz` rises.
- `speed` output, 1 bit: mode bit. 0 selects fast, 1 selects slow. Toggles on each accepted button press.

## Operation
**Dividers**
- Each divider uses a half-period `HALF` = `CLK_FREQ`/(2·Hz):
  - `HALF_FAST` = 5_000_000.
  - `HALF_SLOW` = 50_000_000.
- Counter width is $clog2(`HALF_SLOW`); 26 bits at defaults.
- On each edge:
  - If `cnt`==`HALF`-1: `cnt`←0 and out←~out.
  - Otherwise: `cnt`←`cnt`+1.
- Tick register ← (`cnt`==`HALF`-1) && (out==0). The tick is therefore coincident with the registered rising edge of the output.
- Elaboration-time checks:
  - `CLK_FREQ` divisible by 2·`FAST_HZ`.
  - `FAST_HZ` divisible by `SLOW_HZ`.
  - `FAST_HZ` > `SLOW_HZ`.
  - If any check fails, `$error`.
- Both dividers restart together on reset. Every `clk_1hz` edge therefore coincides with a `clk_10hz` edge, so switching at the selector is glitch-aligned.

**Button path**
- Two-flop synchroniser: `btn_speed` → `s1` → `s2`.
- Debouncer with debounced level `db` and counter `dcnt`:
  - If `s2`==`db`: `dcnt`←0.
  - Else if `dcnt`==`DEB_CYCLES`-1: `db`←`s2` and `dcnt`←0.
  - Else: `dcnt`←`dcnt`+1.
- `speed` toggles on the same edge where `db` goes 0→1. A release (`db` 1→0) never changes `speed`.
- Holding the button produces exactly one toggle.
- Any bounce shorter than `DEB_CYCLES` resets `dcnt` and is ignored.

## Timing
- Reset values: `cnt`s=0, `clk_10hz`=0, `clk_1hz`=0, ticks=0, `s1`=`s2`=0, `db`=0, `dcnt`=0, `speed`=0.
- Reset is honoured on any edge, including mid-period and mid-debounce. All state returns to the reset values on the next edge, and a pending press is discarded.
- After reset release, `clk_10hz` rises on edge `HALF_FAST` and `clk_1hz` rises on edge `HALF_SLOW`, counting the first edge with `rst`=0 as edge 1.
- Output periods are exactly 2·`HALF` cycles, with high and low phases each exactly `HALF` cycles.
- Button latency: a clean 0→1 level on `btn_speed`, sampled at edge n, produces a `speed` toggle at edge n+1+`DEB_CYCLES`. This is 2 synchroniser edges plus `DEB_CYCLES`-1 counting edges.
- Simultaneous events: a divider wrap and a `speed` toggle in the same cycle are independent, and neither delays the other.
- All outputs are registered, with no combinational path from input to output.

## Structure
- A shared package or include holds:
  - `HALF_FAST` and `HALF_SLOW` localparam derivations.
  - The counter-width function.
  - `SPEED_FAST`=1'b0 and `SPEED_SLOW`=1'b1, used by this block and by the selector.
- One sub-module, `freq_div`:
  - Parameter `HALF`.
  - Ports `clk`, `rst`, `clk_out`, `tick`.
  - Instantiated twice.
- The synchroniser, debouncer and toggle stay inline in `speed_clock_gen`.

## Test plan
Simulation parameters: `CLK_FREQ`=200, `FAST_HZ`=10, `SLOW_HZ`=1, `DEB_CYCLES`=4. This gives `HALF_FAST`=10 and `HALF_SLOW`=100.

1. **Reset and first edges:** hold `rst` for 3 cycles, then run 250 cycles. Required: all outputs 0 during reset; `clk_10hz` rises at edge 10 with `tick_10hz` high for that cycle only; `clk_1hz` rises at edge 100; every `clk_1hz` edge coincides with a `clk_10hz` edge.
2. **Duty and period:** measure 5 periods of each output. Required: 20/200 cycles per period, 10/100 cycles high.
3. **Clean press:** drive `btn_speed` 0→1 and hold 20 cycles. Required: `speed` 0→1 exactly 5 edges after the first sampling edge. Releasing and holding low for 20 cycles leaves `speed`=1. A second press sets `speed`=0.
4. **Bounce rejection:** pulses of 1, 2 and 3 cycles high, separated by 1-cycle lows. Required: `speed` unchanged. A following 6-cycle hold produces exactly one toggle.
5. **Reset mid-operation:** assert `rst` at divider count 7 and at debounce count 2 of a press. Required: next edge shows all reset values, `speed`=0, and no toggle once the button is held after reset release before a fresh `DEB_CYCLES` window.

Source files
------------

// File: rtl/speed_clock_gen_pkg.sv
// Shared constants and helpers for the speed-select clock path.
// The downstream clock selector uses the same SPEED_* encoding.
package speed_clock_gen_pkg;

    localparam logic SPEED_FAST = 1'b0;
    localparam logic SPEED_SLOW = 1'b1;

    // Half-period, in board-clock cycles, of a square wave at hz.
    function automatic int half_period(input int clk_freq, input int hz);
        return clk_freq / (2 * hz);
    endfunction

    // Bits needed for a counter that runs from 0 to n-1.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/speed_clock_gen_freq_div.sv
// Square-wave divider: the output toggles every HALF cycles.
// The tick strobe is registered so that it lines up with the rising output edge.
module freq_div
    import speed_clock_gen_pkg::*;
#(
    parameter int HALF = 10
) (
    input  logic clk,
    input  logic rst,
    output logic clk_out,
    output logic tick
);

    localparam int W = cnt_width(HALF);
    localparam logic [W-1:0] LAST = W'(HALF - 1);

    logic [W-1:0] cnt_q, cnt_d;
    logic         out_q, out_d;
    logic         tick_q, tick_d;
    logic         wrap;

    always_comb begin
        wrap   = (cnt_q == LAST);
        cnt_d  = wrap ? '0 : cnt_q + W'(1);
        out_d  = wrap ? ~out_q : out_q;
        tick_d = wrap && !out_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            out_q  <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            out_q  <= out_d;
            tick_q <= tick_d;
        end
    end

    assign clk_out = out_q;
    assign tick    = tick_q;

endmodule

// File: rtl/speed_clock_gen.sv
// Derives the fast and slow square waves and owns the speed mode bit,
// which toggles on each debounced press of btn_speed.
module speed_clock_gen
    import speed_clock_gen_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int FAST_HZ    = 10,
    parameter int SLOW_HZ    = 1,
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_speed,
    output logic clk_10hz,
    output logic clk_1hz,
    output logic tick_10hz,
    output logic tick_1hz,
    output logic speed
);

    localparam int HALF_FAST = half_period(CLK_FREQ, FAST_HZ);
    localparam int HALF_SLOW = half_period(CLK_FREQ, SLOW_HZ);
    localparam int DW        = cnt_width(DEB_CYCLES);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

    if (CLK_FREQ % (2 * FAST_HZ) != 0) begin : g_chk_clk
        $error("CLK_FREQ must be divisible by 2*FAST_HZ");
    end
    if (FAST_HZ % SLOW_HZ != 0) begin : g_chk_ratio
        $error("FAST_HZ must be divisible by SLOW_HZ");
    end
    if (FAST_HZ <= SLOW_HZ) begin : g_chk_order
        $error("FAST_HZ must exceed SLOW_HZ");
    end

    // Both dividers share reset, so every slow edge lands on a fast edge.
    freq_div #(.HALF(HALF_FAST)) u_div_fast (
        .clk     (clk),
        .rst     (rst),
        .clk_out (clk_10hz),
        .tick    (tick_10hz)
    );

    freq_div #(.HALF(HALF_SLOW)) u_div_slow (
        .clk     (clk),
        .rst     (rst),
        .clk_out (clk_1hz),
        .tick    (tick_1hz)
    );

    logic          s1_q, s2_q;
    logic          db_q, db_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic          speed_q, speed_d;

    // A new level is accepted only after DEB_CYCLES consecutive agreeing samples.
    always_comb begin
        db_d    = db_q;
        dcnt_d  = dcnt_q + DW'(1);
        speed_d = speed_q;
        if (s2_q == db_q) begin
            dcnt_d = '0;
        end else if (dcnt_q == DEB_LAST) begin
            db_d   = s2_q;
            dcnt_d = '0;
            if (s2_q) begin
                speed_d = ~speed_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            db_q    <= 1'b0;
            dcnt_q  <= '0;
            speed_q <= SPEED_FAST;
        end else begin
            s1_q    <= btn_speed;
            s2_q    <= s1_q;
            db_q    <= db_d;
            dcnt_q  <= dcnt_d;
            speed_q <= speed_d;
        end
    end

    assign speed = speed_q;

endmodule

// File: tb/tb_speed_clock_gen.sv
// Bench for speed_clock_gen at reduced clock rates: a scoreboard of expected
// output vectors plus a few directed latency and measurement checks.
module tb_speed_clock_gen;

    localparam int HF  = 10;
    localparam int HS  = 100;
    localparam int DEB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_speed = 1'b0;
    logic clk_10hz, clk_1hz, tick_10hz, tick_1hz, speed;

    speed_clock_gen #(
        .CLK_FREQ   (200),
        .FAST_HZ    (10),
        .SLOW_HZ    (1),
        .DEB_CYCLES (DEB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_speed (btn_speed),
        .clk_10hz  (clk_10hz),
        .clk_1hz   (clk_1hz),
        .tick_10hz (tick_10hz),
        .tick_1hz  (tick_1hz),
        .speed     (speed)
    );

    always #5 clk = ~clk;

    int errs   = 0;
    int checks = 0;

    logic [4:0] exp_q[$];
    int         e = 0;
    bit         hist[0:4095];
    bit         db_m  = 1'b0;
    bit         spd_m = 1'b0;
    logic       p10 = 1'b0;
    logic       p1  = 1'b0;
    int         hi10, hi1, r10, r1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, got, exp, e);
        end
    endtask

    function automatic bit samp(input int idx);
        return (idx < 1) ? 1'b0 : hist[idx];
    endfunction

    // Drive one cycle, predict the outputs after the edge, then compare.
    task automatic cycle(input logic r, input logic b);
        logic [4:0] ev;
        logic [4:0] got;
        bit         flip;
        rst       = r;
        btn_speed = b;
        if (r) begin
            e     = 0;
            db_m  = 1'b0;
            spd_m = 1'b0;
        end else begin
            e++;
            hist[e] = b;
            flip = 1'b1;
            // A level seen at edge k reaches the debouncer at edge k+2.
            for (int k = e - 1 - DEB; k <= e - 2; k++) begin
                if (samp(k) == db_m) flip = 1'b0;
            end
            if (flip) begin
                db_m = ~db_m;
                if (db_m) spd_m = ~spd_m;
            end
        end
        ev[4] = ((e / HF) % 2) == 1;
        ev[3] = (e > 0) && ((e % (2 * HF)) == HF);
        ev[2] = ((e / HS) % 2) == 1;
        ev[1] = (e > 0) && ((e % (2 * HS)) == HS);
        ev[0] = spd_m;
        exp_q.push_back(ev);
        @(posedge clk);
        #1;
        got = {clk_10hz, tick_10hz, clk_1hz, tick_1hz, speed};
        check("outputs", 32'(got), 32'(exp_q.pop_front()));
        if (clk_1hz !== p1) check("align", 32'(clk_10hz !== p10), 32'd1);
        p10 = clk_10hz;
        p1  = clk_1hz;
    endtask

    initial begin
        repeat (3) cycle(1'b1, 1'b0);
        repeat (250) cycle(1'b0, 1'b0);

        hi10 = 0; hi1 = 0; r10 = 0; r1 = 0;
        repeat (1000) begin
            cycle(1'b0, 1'b0);
            hi10 += int'(clk_10hz);
            hi1  += int'(clk_1hz);
            r10  += int'(tick_10hz);
            r1   += int'(tick_1hz);
        end
        check("high_10hz", 32'(hi10), 32'd500);
        check("high_1hz", 32'(hi1), 32'd500);
        check("ticks_10hz", 32'(r10), 32'd50);
        check("ticks_1hz", 32'(r1), 32'd5);

        cycle(1'b0, 1'b1);
        for (int i = 1; i <= 20; i++) begin
            cycle(1'b0, 1'b1);
            if (i == 4) check("press_edge4", 32'(speed), 32'd0);
            if (i == 5) check("press_edge5", 32'(speed), 32'd1);
        end
        repeat (20) cycle(1'b0, 1'b0);
        check("release_keeps", 32'(speed), 32'd1);
        repeat (20) cycle(1'b0, 1'b1);
        check("press2", 32'(speed), 32'd0);
        repeat (10) cycle(1'b0, 1'b0);

        cycle(1'b0, 1'b1); cycle(1'b0, 1'b0);
        repeat (2) cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b0);
        repeat (3) cycle(1'b0, 1'b1);
        repeat (6) cycle(1'b0, 1'b0);
        check("bounce", 32'(speed), 32'd0);
        repeat (6) cycle(1'b0, 1'b1);
        repeat (10) cycle(1'b0, 1'b0);
        check("hold6", 32'(speed), 32'd1);

        cycle(1'b1, 1'b0);
        repeat (7) cycle(1'b0, 1'b0);
        cycle(1'b1, 1'b0);
        check("rst_div_speed", 32'(speed), 32'd0);
        check("rst_div_clk", 32'({clk_10hz, tick_10hz, clk_1hz, tick_1hz}), 32'd0);
        cycle(1'b0, 1'b1);
        repeat (3) cycle(1'b0, 1'b1);
        cycle(1'b1, 1'b1);
        check("rst_deb_speed", 32'(speed), 32'd0);
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b0, 1'b1);
            if (i == 5) check("fresh_window5", 32'(speed), 32'd0);
            if (i == 6) check("fresh_window6", 32'(speed), 32'd1);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
